// File: rtl/can_bus_integration_ctrl.sv
// CAN bus integration sequencer: counts recessive bits from the sampled bit
// stream and issues single-cycle strobes to the operation-control FSM.
module can_bus_integration_ctrl #(
  parameter int IDLE_BITS         = 11,
  parameter int INTERMISSION_BITS = 3,
  parameter int BUS_OFF_SEQS      = 128
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic reset_mode_i,
  input  logic sample_i,
  input  logic rx_i,
  input  logic frame_end_i,
  input  logic error_i,
  input  logic bus_off_i,
  output logic go_oc_integrating_o,
  output logic go_oc_receiving_o,
  output logic go_oc_idle_o,
  output logic bus_free_o,
  output logic sof_o,
  output logic overload_o,
  output logic bus_off_recovered_o,
  output logic busy_o
);

  localparam int REC_W = $clog2(IDLE_BITS + 1);
  localparam int INT_W = $clog2(INTERMISSION_BITS + 1);
  localparam int SEQ_W = $clog2(BUS_OFF_SEQS + 1);

  // Terminal values are compared before the increment so no counter ever wraps.
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(IDLE_BITS - 1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(INTERMISSION_BITS - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(BUS_OFF_SEQS - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_INTEGRATING,
    S_IDLE,
    S_RECEIVING,
    S_INTERMISSION,
    S_BUS_OFF
  } state_t;

  state_t           state, state_nxt;
  logic [REC_W-1:0] rec_cnt, rec_nxt;
  logic [INT_W-1:0] int_cnt, int_nxt;
  logic [SEQ_W-1:0] seq_cnt, seq_nxt;

  logic go_int_nxt, go_rx_nxt, go_idle_nxt, bus_free_nxt;
  logic sof_nxt, overload_nxt, recovered_nxt, busy_nxt;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    state_nxt     = state;
    rec_nxt       = rec_cnt;
    int_nxt       = int_cnt;
    seq_nxt       = seq_cnt;
    go_int_nxt    = 1'b0;
    go_rx_nxt     = 1'b0;
    go_idle_nxt   = 1'b0;
    bus_free_nxt  = 1'b0;
    sof_nxt       = 1'b0;
    overload_nxt  = 1'b0;
    recovered_nxt = 1'b0;

    if (reset_mode_i) begin
      state_nxt = S_OFF;
      rec_nxt   = '0;
      int_nxt   = '0;
      seq_nxt   = '0;
    end else if (state == S_OFF) begin
      go_int_nxt = 1'b1;
      state_nxt  = S_INTEGRATING;
      rec_nxt    = '0;
    end else if (bus_off_i) begin
      state_nxt = S_BUS_OFF;
      rec_nxt   = '0;
      seq_nxt   = '0;
    end else begin
      unique case (state)
        S_INTEGRATING: begin
          if (sample_i) begin
            if (!rx_i) begin
              rec_nxt = '0;
            end else if (rec_cnt == REC_LAST) begin
              bus_free_nxt = 1'b1;
              go_idle_nxt  = 1'b1;
              state_nxt    = S_IDLE;
              rec_nxt      = '0;
            end else begin
              rec_nxt = rec_cnt + REC_W'(1);
            end
          end
        end

        S_IDLE: begin
          if (sample_i && !rx_i) begin
            sof_nxt   = 1'b1;
            go_rx_nxt = 1'b1;
            state_nxt = S_RECEIVING;
          end
        end

        S_RECEIVING: begin
          if (error_i) begin
            go_int_nxt = 1'b1;
            state_nxt  = S_INTEGRATING;
            rec_nxt    = '0;
          end else if (frame_end_i) begin
            state_nxt = S_INTERMISSION;
            int_nxt   = '0;
          end
        end

        S_INTERMISSION: begin
          if (error_i) begin
            go_int_nxt = 1'b1;
            state_nxt  = S_INTEGRATING;
            rec_nxt    = '0;
          end else if (sample_i) begin
            if (rx_i) begin
              if (int_cnt == INT_LAST) begin
                go_idle_nxt = 1'b1;
                state_nxt   = S_IDLE;
                int_nxt     = '0;
              end else begin
                int_nxt = int_cnt + INT_W'(1);
              end
            end else if (int_cnt == INT_LAST) begin
              // Dominant on the last intermission bit is a start of frame.
              sof_nxt   = 1'b1;
              go_rx_nxt = 1'b1;
              state_nxt = S_RECEIVING;
              int_nxt   = '0;
            end else begin
              overload_nxt = 1'b1;
              go_int_nxt   = 1'b1;
              state_nxt    = S_INTEGRATING;
              rec_nxt      = '0;
              int_nxt      = '0;
            end
          end
        end

        S_BUS_OFF: begin
          if (sample_i) begin
            if (!rx_i) begin
              rec_nxt = '0;
            end else if (rec_cnt == REC_LAST) begin
              rec_nxt = '0;
              if (seq_cnt == SEQ_LAST) begin
                recovered_nxt = 1'b1;
                bus_free_nxt  = 1'b1;
                go_idle_nxt   = 1'b1;
                state_nxt     = S_IDLE;
                seq_nxt       = '0;
              end else begin
                seq_nxt = seq_cnt + SEQ_W'(1);
              end
            end else begin
              rec_nxt = rec_cnt + REC_W'(1);
            end
          end
        end

        default: state_nxt = S_OFF;
      endcase
    end

    busy_nxt = (state_nxt == S_RECEIVING) || (state_nxt == S_INTERMISSION);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= S_OFF;
      rec_cnt             <= '0;
      int_cnt             <= '0;
      seq_cnt             <= '0;
      go_oc_integrating_o <= 1'b0;
      go_oc_receiving_o   <= 1'b0;
      go_oc_idle_o        <= 1'b0;
      bus_free_o          <= 1'b0;
      sof_o               <= 1'b0;
      overload_o          <= 1'b0;
      bus_off_recovered_o <= 1'b0;
      busy_o              <= 1'b0;
    end else begin
      state               <= state_nxt;
      rec_cnt             <= rec_nxt;
      int_cnt             <= int_nxt;
      seq_cnt             <= seq_nxt;
      go_oc_integrating_o <= go_int_nxt;
      go_oc_receiving_o   <= go_rx_nxt;
      go_oc_idle_o        <= go_idle_nxt;
      bus_free_o          <= bus_free_nxt;
      sof_o               <= sof_nxt;
      overload_o          <= overload_nxt;
      bus_off_recovered_o <= recovered_nxt;
      busy_o              <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_can_bus_integration_ctrl.sv
// Bench for can_bus_integration_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random traffic against an event-level model.
module tb_can_bus_integration_ctrl;

  localparam int IDLE_BITS         = 11;
  localparam int INTERMISSION_BITS = 3;
  localparam int BUS_OFF_SEQS      = 128;
  localparam int RANDOM_CYCLES     = 4000;

  // Stimulus bits: {reset_mode, sample, rx, frame_end, error, bus_off}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_R    = 6'b011000;
  localparam logic [5:0] I_D    = 6'b010000;
  localparam logic [5:0] I_FE   = 6'b000100;
  localparam logic [5:0] I_ERR  = 6'b000010;
  localparam logic [5:0] I_BO   = 6'b000001;
  localparam logic [5:0] I_RM   = 6'b100000;

  // Output bits: {go_int, go_rx, go_idle, bus_free, sof, overload, recovered, busy}
  localparam logic [7:0] O_NONE = 8'h00;
  localparam logic [7:0] O_GI   = 8'h80;
  localparam logic [7:0] O_GR   = 8'h40;
  localparam logic [7:0] O_GID  = 8'h20;
  localparam logic [7:0] O_BF   = 8'h10;
  localparam logic [7:0] O_SOF  = 8'h08;
  localparam logic [7:0] O_OVL  = 8'h04;
  localparam logic [7:0] O_REC  = 8'h02;
  localparam logic [7:0] O_BUSY = 8'h01;

  typedef enum int {P_OFF, P_INTEG, P_IDLE, P_RX, P_IMS, P_BOFF} phase_t;

  typedef struct {
    logic [5:0] stim;
    logic [7:0] exp;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] stim  = I_RM;
  logic [7:0] got;

  logic go_oc_integrating_o, go_oc_receiving_o, go_oc_idle_o, bus_free_o;
  logic sof_o, overload_o, bus_off_recovered_o, busy_o;

  int total = 0;
  int bad   = 0;

  phase_t m_phase;
  int     m_run, m_ims, m_seqs;

  can_bus_integration_ctrl #(
    .IDLE_BITS        (IDLE_BITS),
    .INTERMISSION_BITS(INTERMISSION_BITS),
    .BUS_OFF_SEQS     (BUS_OFF_SEQS)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .reset_mode_i       (stim[5]),
    .sample_i           (stim[4]),
    .rx_i               (stim[3]),
    .frame_end_i        (stim[2]),
    .error_i            (stim[1]),
    .bus_off_i          (stim[0]),
    .go_oc_integrating_o(go_oc_integrating_o),
    .go_oc_receiving_o  (go_oc_receiving_o),
    .go_oc_idle_o       (go_oc_idle_o),
    .bus_free_o         (bus_free_o),
    .sof_o              (sof_o),
    .overload_o         (overload_o),
    .bus_off_recovered_o(bus_off_recovered_o),
    .busy_o             (busy_o)
  );

  assign got = {go_oc_integrating_o, go_oc_receiving_o, go_oc_idle_o, bus_free_o,
                sof_o, overload_o, bus_off_recovered_o, busy_o};

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("FAIL %s at %0t: outputs=%b required=%b", name, $time, actual, required);
    end
  endtask

  task automatic model_reset();
    m_phase = P_OFF;
    m_run   = 0;
    m_ims   = 0;
    m_seqs  = 0;
  endtask

  // Event-level reference: pick the winning event by priority, then apply it.
  task automatic model_step(input logic [5:0] s, output logic [7:0] e);
    logic rm, smp, rx, fe, err, bo;
    {rm, smp, rx, fe, err, bo} = s;
    e = O_NONE;
    if (rm) begin
      model_reset();
    end else if (m_phase == P_OFF) begin
      e = O_GI;
      m_phase = P_INTEG;
      m_run = 0;
    end else if (bo) begin
      m_phase = P_BOFF;
      m_run = 0;
      m_seqs = 0;
    end else if (err && (m_phase == P_RX || m_phase == P_IMS)) begin
      e = O_GI;
      m_phase = P_INTEG;
      m_run = 0;
    end else if (fe && m_phase == P_RX) begin
      m_phase = P_IMS;
      m_ims = 0;
    end else if (smp) begin
      case (m_phase)
        P_INTEG: begin
          m_run = rx ? m_run + 1 : 0;
          if (m_run == IDLE_BITS) begin
            e = O_BF | O_GID;
            m_phase = P_IDLE;
            m_run = 0;
          end
        end
        P_IDLE: if (!rx) begin
          e = O_SOF | O_GR;
          m_phase = P_RX;
        end
        P_IMS: begin
          if (rx) begin
            m_ims++;
            if (m_ims == INTERMISSION_BITS) begin
              e = O_GID;
              m_phase = P_IDLE;
            end
          end else if (m_ims == INTERMISSION_BITS - 1) begin
            e = O_SOF | O_GR;
            m_phase = P_RX;
          end else begin
            e = O_OVL | O_GI;
            m_phase = P_INTEG;
            m_run = 0;
          end
        end
        P_BOFF: begin
          m_run = rx ? m_run + 1 : 0;
          if (m_run == IDLE_BITS) begin
            m_seqs++;
            m_run = 0;
          end
          if (m_seqs == BUS_OFF_SEQS) begin
            e = O_REC | O_BF | O_GID;
            m_phase = P_IDLE;
            m_seqs = 0;
          end
        end
        default: ;
      endcase
    end
    if (m_phase == P_RX || m_phase == P_IMS) e = e | O_BUSY;
  endtask

  // One clock: drive, clock, advance the model, compare #1 after the edge.
  task automatic run(input logic [5:0] s, input logic [7:0] required, input bit use_model,
                     input string name);
    logic [7:0] m_exp;
    stim = s;
    @(posedge clk_i);
    #1;
    model_step(s, m_exp);
    check(name, got, use_model ? m_exp : required);
  endtask

  vec_t tbl[$];

  initial begin
    // Table: integration with an interrupted run, then a frame and intermission.
    tbl.push_back('{I_NONE, O_GI});
    for (int i = 0; i < 10; i++) tbl.push_back('{I_R, O_NONE});
    tbl.push_back('{I_D, O_NONE});
    for (int i = 0; i < IDLE_BITS - 1; i++) tbl.push_back('{I_R, O_NONE});
    tbl.push_back('{I_R, O_BF | O_GID});
    tbl.push_back('{I_R, O_NONE});
    tbl.push_back('{I_D, O_SOF | O_GR | O_BUSY});
    tbl.push_back('{I_R, O_BUSY});
    tbl.push_back('{I_FE, O_BUSY});
    tbl.push_back('{I_R, O_BUSY});
    tbl.push_back('{I_R, O_BUSY});
    tbl.push_back('{I_R, O_GID});

    model_reset();
    #12;
    check("reset_state", got, O_NONE);
    @(negedge clk_i);
    rst_i = 1'b0;
    run(I_RM, O_NONE, 0, "reset_mode_hold");
    run(I_RM, O_NONE, 0, "reset_mode_hold2");

    foreach (tbl[i]) run(tbl[i].stim, tbl[i].exp, 0, $sformatf("table[%0d]", i));

    // Intermission R,R,D is a start of frame.
    run(I_D, O_SOF | O_GR | O_BUSY, 0, "sof_idle");
    run(I_FE, O_BUSY, 0, "frame_end");
    run(I_R, O_BUSY, 0, "ims_r1");
    run(I_R, O_BUSY, 0, "ims_r2");
    run(I_D, O_SOF | O_GR | O_BUSY, 0, "ims_sof");
    // Intermission R,D is an overload, followed by re-integration.
    run(I_FE, O_BUSY, 0, "frame_end2");
    run(I_R, O_BUSY, 0, "ims_r1b");
    run(I_D, O_OVL | O_GI, 0, "overload");
    for (int i = 1; i <= IDLE_BITS; i++)
      run(I_R, (i == IDLE_BITS) ? (O_BF | O_GID) : O_NONE, 0, "reintegrate");

    // Error wins over a coincident frame end; no intermission follows.
    run(I_D, O_SOF | O_GR | O_BUSY, 0, "sof_err");
    run(I_ERR | I_FE, O_GI, 0, "error_over_fe");
    for (int i = 1; i <= IDLE_BITS; i++)
      run(I_R, (i == IDLE_BITS) ? (O_BF | O_GID) : O_NONE, 0, "err_integrate");

    // Bus-off recovery with a dominant bit inside sequence 64.
    run(I_BO, O_NONE, 0, "bus_off_enter");
    for (int q = 1; q <= BUS_OFF_SEQS; q++) begin
      if (q == 64) begin
        repeat (4) run(I_R, O_NONE, 0, "bus_off_seq64_pre");
        run(I_D, O_NONE, 0, "bus_off_dominant");
      end
      for (int b = 1; b <= IDLE_BITS; b++)
        run(I_R, (q == BUS_OFF_SEQS && b == IDLE_BITS) ? (O_REC | O_BF | O_GID) : O_NONE,
            0, "bus_off_seq");
    end
    run(I_R, O_NONE, 0, "idle_after_recovery");

    // reset_mode together with bus_off mid-frame.
    run(I_D, O_SOF | O_GR | O_BUSY, 0, "sof_rm");
    run(I_RM | I_BO, O_NONE, 0, "rm_with_bus_off");
    run(I_RM | I_D, O_NONE, 0, "rm_sample_discarded");
    run(I_NONE, O_GI, 0, "rm_release");

    // Asynchronous reset mid-frame.
    for (int i = 1; i <= IDLE_BITS; i++)
      run(I_R, (i == IDLE_BITS) ? (O_BF | O_GID) : O_NONE, 0, "pre_rst_integrate");
    run(I_D, O_SOF | O_GR | O_BUSY, 0, "pre_rst_sof");
    stim  = I_NONE;
    rst_i = 1'b1;
    #1;
    check("async_reset_outputs", got, O_NONE);
    model_reset();
    @(posedge clk_i);
    #1;
    check("reset_held", got, O_NONE);
    rst_i = 1'b0;
    run(I_NONE, O_GI, 0, "post_rst_integrating");

    for (int c = 0; c < RANDOM_CYCLES; c++) begin
      logic [5:0] s;
      s[5] = ($urandom_range(0, 499) == 0);
      s[4] = ($urandom_range(0, 1) == 1);
      s[3] = ($urandom_range(0, 99) < 85);
      s[2] = ($urandom_range(0, 19) == 0);
      s[1] = ($urandom_range(0, 39) == 0);
      s[0] = ($urandom_range(0, 299) == 0);
      run(s, O_NONE, 1, $sformatf("random[%0d] stim=%b", c, s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_bus_integration_ctrl.md
Name: can_bus_integration_ctrl

Overview:
Sequencer that drives the CAN operation-control state machine from the sampled bit stream. It counts recessive bits to detect bus integration, SOF, end of intermission, overload conditions and bus-off recovery. It issues single-cycle go_oc_* and bus_free strobes to the operation-control FSM. It sits between the bit-timing logic (sample strobe, rx bit) and the operation-control/bit-stream-processor blocks.

Parameters:
IDLE_BITS, 11, consecutive recessive bits required for integration / bus-free
INTERMISSION_BITS, 3, recessive bits forming intermission after frame end
BUS_OFF_SEQS, 128, occurrences of IDLE_BITS recessive bits required for bus-off recovery

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
reset_mode_i  in  1  controller reset mode (level); holds block in S_OFF
sample_i  in  1  one-cycle strobe at bit sample point
rx_i  in  1  sampled bus value, valid when sample_i=1 (1=recessive)
frame_end_i  in  1  pulse: EOF of a received frame completed
error_i  in  1  pulse: error detected during frame
bus_off_i  in  1  pulse: error counters entered bus-off
go_oc_integrating_o  out  1  pulse: enter integrating
go_oc_receiving_o  out  1  pulse: enter receiving
go_oc_idle_o  out  1  pulse: enter idle
bus_free_o  out  1  pulse: IDLE_BITS recessive bits seen
sof_o  out  1  pulse: start of frame detected
overload_o  out  1  pulse: dominant in intermission bit 1 or 2
bus_off_recovered_o  out  1  pulse: bus-off recovery complete
busy_o  out  1  level: state is S_RECEIVING or S_INTERMISSION

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-high on rst_i. Reset state S_OFF; all counters 0; all outputs 0.
- All outputs are registered. Pulses are exactly 1 cycle wide and appear the cycle after the triggering sample/input edge.
- Counters: rec_cnt width $clog2(IDLE_BITS+1); int_cnt width $clog2(INTERMISSION_BITS+1); seq_cnt width $clog2(BUS_OFF_SEQS+1). No wrap: each counter is cleared on the transition that consumes its terminal value.
- Priority each cycle: reset_mode_i > bus_off_i > error_i > frame_end_i > sample_i events.
- reset_mode_i=1 (any state): synchronous move to S_OFF; counters cleared; no pulses.
- S_OFF: when reset_mode_i=0, pulse go_oc_integrating_o and go to S_INTEGRATING with rec_cnt=0.
- S_INTEGRATING, on sample_i:
  - rx_i=1: rec_cnt++.
  - rx_i=0: rec_cnt=0.
  - When the sample makes rec_cnt==IDLE_BITS: pulse bus_free_o and go_oc_idle_o (same cycle), go to S_IDLE, clear rec_cnt.
- S_IDLE, on sample_i with rx_i=0: pulse sof_o and go_oc_receiving_o; go to S_RECEIVING. Recessive samples are ignored.
- S_RECEIVING:
  - frame_end_i: go to S_INTERMISSION, int_cnt=0.
  - error_i: pulse go_oc_integrating_o, go to S_INTEGRATING, rec_cnt=0 (error delimiter plus intermission = IDLE_BITS recessive).
  - Samples are ignored.
- S_INTERMISSION, on sample_i:
  - rx_i=1: int_cnt++. When int_cnt reaches INTERMISSION_BITS: pulse go_oc_idle_o, go to S_IDLE.
  - rx_i=0 with int_cnt==INTERMISSION_BITS-1 (last bit): treat as SOF; pulse sof_o and go_oc_receiving_o; go to S_RECEIVING.
  - rx_i=0 with int_cnt<INTERMISSION_BITS-1: pulse overload_o and go_oc_integrating_o; go to S_INTEGRATING, rec_cnt=0.
  - error_i: same handling as in S_RECEIVING.
- bus_off_i in any state except S_OFF: go to S_BUS_OFF; rec_cnt=0, seq_cnt=0; no go_* pulse.
- S_BUS_OFF, on sample_i:
  - rx_i=1: rec_cnt++. When it reaches IDLE_BITS: seq_cnt++ and rec_cnt=0.
  - rx_i=0: rec_cnt=0; seq_cnt is kept.
  - When seq_cnt reaches BUS_OFF_SEQS: pulse bus_off_recovered_o, bus_free_o and go_oc_idle_o together; go to S_IDLE; clear counters.
  - error_i and frame_end_i are ignored.
- frame_end_i or error_i outside the states listed above: ignored.
- sample_i coincident with a higher-priority event: the sample is discarded.
- rst_i asserted mid-operation: immediate S_OFF, outputs 0 while asserted. After deassertion, and with reset_mode_i=0, go_oc_integrating_o pulses on the next clock.

Test Plan:
1. Release reset_mode_i; 10 recessive samples, 1 dominant, then 11 recessive -> go_oc_integrating_o once; bus_free_o and go_oc_idle_o pulse exactly once, after sample 22.
2. In S_IDLE, one dominant sample -> sof_o and go_oc_receiving_o in the same cycle; busy_o=1. Then frame_end_i followed by 3 recessive samples -> go_oc_idle_o after the 3rd sample; busy_o=0.
3. Intermission samples R,R,D -> sof_o and go_oc_receiving_o. Separately, samples R,D -> overload_o and go_oc_integrating_o; 11 further recessive samples -> bus_free_o.
4. error_i during S_RECEIVING with frame_end_i in the same cycle -> error wins: go_oc_integrating_o, and no S_INTERMISSION entry.
5. bus_off_i, then 128x11 recessive samples with a dominant sample inserted at sample 5 of sequence 64 -> bus_off_recovered_o exactly when the 128th complete sequence finishes; seq_cnt is not reset by the dominant sample.
6. reset_mode_i asserted mid-frame together with bus_off_i -> S_OFF, no pulses; after deassertion -> go_oc_integrating_o on the next cycle.
